// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO peripheral: register offsets and the SoC address map.
package gpio_ctrl_pkg;

    localparam logic [31:0] SOC_IMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] SOC_DMEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] GPIO_BASE_ADDR = 32'hFFFF_0000;

    localparam logic [1:0] GPIO_REG_LED   = 2'd0;
    localparam logic [1:0] GPIO_REG_BTN   = 2'd1;
    localparam logic [1:0] GPIO_REG_EDGE  = 2'd2;
    localparam logic [1:0] GPIO_REG_IRQEN = 2'd3;

endpackage

// File: rtl/gpio_ctrl_if.sv
// CPU-side bus of the GPIO peripheral: decoder select, word offset, strobes and data.
interface gpio_ctrl_if;

    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output addr, output we, output re, output wdata, input rdata);
    modport slave  (input sel, input addr, input we, input re, input wdata, output rdata);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level with a
// single-cycle rising pulse coincident with the level update.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic g_clk,
    input  logic g_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    assign w_expire = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_expire & r_sync2;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: LED register, debounced buttons, sticky W1C edge flags and a
// maskable level interrupt, behind a registered-read CPU bus.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int N_LEDS          = 9,
    parameter int N_BTNS          = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic              g_clk,
    input  logic              g_rst,
    gpio_ctrl_if.slave        bus,
    input  logic [N_BTNS-1:0] g_buttons,
    output logic [N_LEDS-1:0] g_leds,
    output logic              irq
);

    logic [N_LEDS-1:0] r_led_out;
    logic [N_BTNS-1:0] r_btn_edge;
    logic [N_BTNS-1:0] r_irq_en;
    logic [31:0]       r_rdata;

    logic [N_BTNS-1:0] w_level;
    logic [N_BTNS-1:0] w_rise;
    logic [N_BTNS-1:0] w_clr;
    logic [31:0]       w_rd_val;
    logic              w_wr;
    logic              w_rd;
    logic              w_unused_wdata;

    for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn_debounce (
            .g_clk   (g_clk),
            .g_rst   (g_rst),
            .i_btn   (g_buttons[i]),
            .o_level (w_level[i]),
            .o_rise  (w_rise[i])
        );
    end

    assign w_wr  = bus.sel & bus.we;
    assign w_rd  = bus.sel & bus.re;
    assign w_clr = (w_wr && bus.addr == GPIO_REG_EDGE) ? bus.wdata[N_BTNS-1:0] : '0;

    // Only the low N bits of wdata land in registers; the rest are deliberately dropped.
    assign w_unused_wdata = ^bus.wdata;

    // NOTE: default assigned before the case so no path leaves w_rd_val unassigned (no latch).
    always_comb begin
        w_rd_val = '0;
        case (bus.addr)
            GPIO_REG_LED:   w_rd_val = 32'(r_led_out);
            GPIO_REG_BTN:   w_rd_val = 32'(w_level);
            GPIO_REG_EDGE:  w_rd_val = 32'(r_btn_edge);
            GPIO_REG_IRQEN: w_rd_val = 32'(r_irq_en);
            default:        w_rd_val = '0;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            r_led_out  <= '0;
            r_btn_edge <= '0;
            r_irq_en   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_wr && bus.addr == GPIO_REG_LED) begin
                r_led_out <= bus.wdata[N_LEDS-1:0];
            end
            if (w_wr && bus.addr == GPIO_REG_IRQEN) begin
                r_irq_en <= bus.wdata[N_BTNS-1:0];
            end
            // A new edge arriving with its clear keeps the flag set.
            r_btn_edge <= (r_btn_edge & ~w_clr) | w_rise;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign g_leds    = r_led_out;
    assign irq       = |(r_btn_edge & r_irq_en);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl with DEBOUNCE_CYCLES=4 (button change visible after 6 cycles).
module tb_gpio_ctrl;

    localparam int N_LEDS = 9;
    localparam int N_BTNS = 8;
    localparam int DEB    = 4;

    logic              g_clk;
    logic              g_rst;
    logic [N_BTNS-1:0] g_buttons;
    logic [N_LEDS-1:0] g_leds;
    logic              irq;
    logic [31:0]       d;

    int errors = 0;
    int checks = 0;

    gpio_ctrl_if bus ();

    gpio_ctrl #(
        .N_LEDS          (N_LEDS),
        .N_BTNS          (N_BTNS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .bus       (bus),
        .g_buttons (g_buttons),
        .g_leds    (g_leds),
        .irq       (irq)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = v;
        @(posedge g_clk); #1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        bus.sel = 1'b1; bus.re = 1'b1; bus.addr = a;
        @(posedge g_clk); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        v = bus.rdata;
    endtask

    task automatic test_reset();
        @(posedge g_clk); #1;
        checks++; if (g_leds !== 9'h000) begin errors++; $display("FAIL reset_leds: got %h want 000", g_leds); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", i, d); end
        end
    endtask

    task automatic test_leds();
        bus_write(2'd0, 32'h0000_01A5);
        checks++; if (g_leds !== 9'h1A5) begin errors++; $display("FAIL led_drive: got %h want 1a5", g_leds); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0000_01A5) begin errors++; $display("FAIL led_read: got %h want 000001a5", d); end
        // Same-cycle read and write of LED_OUT returns the old value.
        bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b1; bus.addr = 2'd0; bus.wdata = 32'h0000_00F0;
        @(posedge g_clk); #1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0;
        checks++; if (bus.rdata !== 32'h0000_01A5) begin errors++; $display("FAIL rw_same_cycle: got %h want 000001a5", bus.rdata); end
        checks++; if (g_leds !== 9'h0F0) begin errors++; $display("FAIL rw_led_new: got %h want 0f0", g_leds); end
        idle(2);
        checks++; if (bus.rdata !== 32'h0000_01A5) begin errors++; $display("FAIL rdata_hold: got %h want 000001a5", bus.rdata); end
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0000_01FF) begin errors++; $display("FAIL led_upper_zero: got %h want 000001ff", d); end
    endtask

    task automatic test_glitch();
        bus_write(2'd3, 32'h0000_0001);
        g_buttons[0] = 1'b1;
        idle(3);
        g_buttons[0] = 1'b0;
        idle(8);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_btn: got %h want 0", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h want 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", irq); end
        bus_write(2'd3, 32'h0);
    endtask

    task automatic test_button_hold();
        g_buttons[3] = 1'b1;
        idle(5);
        bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 2'd1;
        @(posedge g_clk); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL hold_btn_cycle5: got %h want 0", bus.rdata); end
        @(posedge g_clk); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        checks++; if (bus.rdata !== 32'h08) begin errors++; $display("FAIL hold_btn_cycle6: got %h want 08", bus.rdata); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL hold_edge: got %h want 08", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hold_irq_masked: got %b want 0", irq); end
        bus_write(2'd3, 32'h08);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hold_irq_enabled: got %b want 1", irq); end
    endtask

    task automatic test_w1c();
        g_buttons[0] = 1'b1;
        idle(8);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h09) begin errors++; $display("FAIL w1c_pre: got %h want 09", d); end
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL w1c_clear: got %h want 08", d); end
        g_buttons[0] = 1'b0;
        idle(8);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL w1c_fall_btn: got %h want 08", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL w1c_fall_nocapture: got %h want 08", d); end
        // The clear lands on the same edge that sets the new bit-0 flag.
        g_buttons[0] = 1'b1;
        idle(5);
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h09) begin errors++; $display("FAIL w1c_edge_wins: got %h want 09", d); end
    endtask

    task automatic test_reset_mid();
        bus_write(2'd0, 32'h0000_01FF);
        bus_read(2'd0, d);
        g_buttons[1] = 1'b1;
        idle(4);
        #2;
        g_rst = 1'b1;
        #1;
        checks++; if (g_leds !== 9'h000) begin errors++; $display("FAIL rst_async_leds: got %h want 000", g_leds); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_async_rdata: got %h want 0", bus.rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b want 0", irq); end
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_edge_cleared: got %h want 0", d); end
        idle(4);
        bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 2'd1;
        @(posedge g_clk); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_btn_cycle5: got %h want 0", bus.rdata); end
        @(posedge g_clk); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        checks++; if (bus.rdata !== 32'h0B) begin errors++; $display("FAIL rst_btn_cycle6: got %h want 0b", bus.rdata); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0B) begin errors++; $display("FAIL rst_edge_after: got %h want 0b", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_led_reg: got %h want 0", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_irqen_reg: got %h want 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_after: got %b want 0", irq); end
    endtask

    task automatic test_readonly();
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0B) begin errors++; $display("FAIL ro_btn: got %h want 0b", d); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL irqen_upper_zero: got %h want 000000ff", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ro_irq_on: got %b want 1", irq); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ro_irq_off: got %b want 0", irq); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ro_edge_cleared: got %h want 0", d); end
    endtask

    initial begin
        g_rst     = 1'b1;
        g_buttons = '0;
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = '0;
        test_reset();
        test_leds();
        test_glitch();
        test_button_hold();
        test_w1c();
        test_reset_mid();
        test_readonly();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
